// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch front end. Address width and group
// size come from the INST_ADDR_WIDTH / FETCH_WIDTH macros (defaults 16 / 2).
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 16
`endif
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 2
`endif

package fetch_pkg;
   localparam int ADDR_W      = `INST_ADDR_WIDTH;
   localparam int FW          = `FETCH_WIDTH;
   localparam int FETCH_BYTES = 4 * FW;

   localparam logic [1:0] S_INIT     = 2'd0;
   localparam logic [1:0] S_FETCH    = 2'd1;
   localparam logic [1:0] S_REDIRECT = 2'd2;

   typedef enum logic [1:0] {
      INIT     = S_INIT,
      FETCH    = S_FETCH,
      REDIRECT = S_REDIRECT
   } fetch_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0]       pc;
      logic [FW-1:0][31:0]     inst;
   } fetch_group_t;
endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetch groups. Flush wins over push; storage is not reset,
// only the pointers and occupancy count.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_group_t din,
   output logic         full,
   output logic         empty,
   output fetch_group_t head
);
   localparam int PTR_W = $clog2(DEPTH);

   fetch_group_t     store [DEPTH];
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W:0]   count_reg;
   logic             pop_ok;

   assign full   = (count_reg == (PTR_W+1)'(DEPTH));
   assign empty  = (count_reg == '0);
   assign pop_ok = pop && !empty;
   // When empty the head is pinned to entry 0 so the outputs never float on a stale pointer.
   assign head   = empty ? store[0] : store[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (push && !flush)
         store[wr_ptr_reg] <= din;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop_ok)
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         unique case ({push, pop_ok})
            2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
            2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: PC, INIT/FETCH/REDIRECT FSM and fetch queue. Defining
// FETCH_CTRL_PERF_EN adds saturating perf_groups/perf_stall/perf_redirects.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int                         INST_ADDR_WIDTH = ADDR_W,
   parameter int                         FETCH_WIDTH     = FW,
   parameter int                         QUEUE_DEPTH     = 4,
   parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC        = '0
) (
   input  logic                         clk,
   input  logic                         reset,
   output logic [INST_ADDR_WIDTH-1:0]   mem_pc,
   input  logic [32*FETCH_WIDTH-1:0]    mem_inst,
   input  logic                         redirect_valid,
   input  logic [INST_ADDR_WIDTH-1:0]   redirect_pc,
   output logic                         fq_valid,
   input  logic                         fq_ready,
   output logic [INST_ADDR_WIDTH-1:0]   fq_pc,
   output logic [32*FETCH_WIDTH-1:0]    fq_inst
`ifdef FETCH_CTRL_PERF_EN
   ,
   output logic [31:0]                  perf_groups,
   output logic [31:0]                  perf_stall,
   output logic [31:0]                  perf_redirects
`endif
);
   logic [1:0]                 state_reg, state_next;
   logic [INST_ADDR_WIDTH-1:0] pc_reg, pc_next;
   logic                       push, pop, stall, full, empty;
   fetch_group_t               din, head;

   assign mem_pc   = pc_reg;
   assign fq_valid = !empty;
   assign pop      = !empty && fq_ready;
   // fq_ready only matters here when the queue is full and its head leaves this cycle.
   assign push     = (state_reg == S_FETCH) && !redirect_valid && (!full || pop);
   assign stall    = (state_reg == S_FETCH) && !redirect_valid && full && !pop;
   assign din.pc   = pc_reg;
   assign din.inst = mem_inst;
   assign fq_pc    = head.pc;
   assign fq_inst  = head.inst;

   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      if (redirect_valid) begin
         state_next = S_REDIRECT;
         pc_next    = redirect_pc & ~INST_ADDR_WIDTH'(3);
      end else begin
         unique case (state_reg)
            S_INIT:     state_next = S_FETCH;
            S_REDIRECT: state_next = S_FETCH;
            S_FETCH:    if (push) pc_next = pc_reg + INST_ADDR_WIDTH'(FETCH_BYTES);
            default:    state_next = S_INIT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= S_INIT;
         pc_reg    <= RESET_PC;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
      end
   end

   fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .din   (din),
      .full  (full),
      .empty (empty),
      .head  (head)
   );

`ifdef FETCH_CTRL_PERF_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_groups    <= '0;
         perf_stall     <= '0;
         perf_redirects <= '0;
      end else begin
         if (push && (perf_groups != '1))
            perf_groups <= perf_groups + 32'd1;
         if (stall && (perf_stall != '1))
            perf_stall <= perf_stall + 32'd1;
         if (redirect_valid && (perf_redirects != '1))
            perf_redirects <= perf_redirects + 32'd1;
      end
   end
`else
   logic unused_stall;
   assign unused_stall = stall;
`endif
endmodule
